// File: rtl/serial_fxp_pkg.sv
// Shared types and constants for the digit-serial fixed-point blocks.
// The sat_* helpers support widths up to 64 bits.
package serial_fxp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Most positive two's complement value of a w-bit word (0x7F..F).
  function automatic logic [63:0] sat_max(input int unsigned w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative two's complement value of a w-bit word (0x80..0).
  function automatic logic [63:0] sat_min(input int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/serial_addsub_digit.sv
// Combinational DIGIT-bit ripple-carry adder slice; also exposes the carry
// into its top bit so the caller can form signed overflow on the last digit.
module serial_addsub_digit #(
  parameter int unsigned DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             cmsb
);

  logic [DIGIT:0] c;

  // Ripple the carry through the digit, LSB first.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[DIGIT];
    cmsb = c[DIGIT-1];
  end

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial two's complement adder/subtractor with valid/ready handshakes.
// Processes DIGIT bits per cycle LSB first; one result every WIDTH/DIGIT + 2
// cycles. Optional saturation on signed overflow: define SERIAL_ADD_SAT_EN.
module serial_addsub
  import serial_fxp_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             asyn_reset,
  input  logic [WIDTH-1:0] x,
  input  logic             data_x_vld,
  output logic             data_x_rdy,
  input  logic [WIDTH-1:0] y,
  input  logic             data_y_vld,
  output logic             data_y_rdy,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             d_out_vld,
  input  logic             d_out_rdy
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t           state_q, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, sum_q, sum_nxt, sum_fin;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, cout_q, ovf_q, vld_q;
  logic             accept, last_step, ovf_nxt;
  logic [DIGIT-1:0] dsum;
  logic             dcout, dcmsb;

  serial_addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .a    (a_q[DIGIT-1:0]),
    .b    (b_q[DIGIT-1:0]),
    .cin  (carry_q),
    .s    (dsum),
    .cout (dcout),
    .cmsb (dcmsb)
  );

`ifdef SERIAL_ADD_SAT_EN
  localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH));
`endif

  // Next state: join both operand valids in IDLE, count N steps, wait for sink.
  always_comb begin
    state_nxt = state_q;
    accept    = 1'b0;
    last_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (data_x_vld && data_y_vld) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (cnt_q == LAST) begin
          last_step = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (d_out_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Result shift and final-value selection. The wrapped MSB tells the overflow
  // direction: both operands share a sign, so a set MSB means positive overflow.
  always_comb begin
    sum_nxt                    = sum_q >> DIGIT;
    sum_nxt[WIDTH-1 -: DIGIT]  = dsum;
    ovf_nxt                    = dcmsb ^ dcout;
    sum_fin                    = sum_nxt;
`ifdef SERIAL_ADD_SAT_EN
    if (ovf_nxt) sum_fin = sum_nxt[WIDTH-1] ? SAT_MAX : SAT_MIN;
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge asyn_reset) begin
    if (!asyn_reset) state_q <= IDLE;
    else             state_q <= state_nxt;
  end

  // Operand shift registers, carry, step counter and result registers.
  always_ff @(posedge clk or negedge asyn_reset) begin
    if (!asyn_reset) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      vld_q <= (state_nxt == DONE);
      if (accept) begin
        a_q     <= x;
        b_q     <= y ^ {WIDTH{sub}};
        carry_q <= sub;
        cnt_q   <= '0;
      end else if (state_q == CALC) begin
        a_q     <= a_q >> DIGIT;
        b_q     <= b_q >> DIGIT;
        carry_q <= dcout;
        if (last_step) begin
          cnt_q  <= '0;
          sum_q  <= sum_fin;
          cout_q <= dcout;
          ovf_q  <= ovf_nxt;
        end else begin
          cnt_q  <= cnt_q + 1'b1;
          sum_q  <= sum_nxt;
        end
      end
    end
  end

  // Ready decodes the state register; forced low while reset is held.
  assign data_x_rdy = (state_q == IDLE) && asyn_reset;
  assign data_y_rdy = (state_q == IDLE) && asyn_reset;
  assign sum        = sum_q;
  assign cout       = cout_q;
  assign ovf        = ovf_q;
  assign d_out_vld  = vld_q;

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Digit-serial fixed-point adder/subtractor with valid/ready handshaking on both operands and the result. Parametrised generalisation of the team's 8-bit serial adder, adding:
- configurable word and digit width;
- a per-transaction add/subtract mode;
- signed-overflow reporting;
- optional saturation.

Sits between operand FIFOs and the downstream fixed-point datapath. Processes DIGIT bits per cycle, LSB first.

## Interface
- WIDTH, 8: operand/result width in bits, two's complement; must be ≥2.
- DIGIT, 1: bits processed per clock; WIDTH % DIGIT must be 0.
- clk  in  1  clock; all state updates on rising edge.
- asyn_reset  in  1  asynchronous, active-low reset (asserted at 0).
- x  in  WIDTH  operand A.
- data_x_vld  in  1  x valid.
- data_x_rdy  out  1  block can accept x.
- y  in  WIDTH  operand B.
- data_y_vld  in  1  y valid.
- data_y_rdy  out  1  block can accept y.
- sub  in  1  mode, sampled with operands: 0 = x+y, 1 = x−y.
- sum  out  WIDTH  result.
- cout  out  1  final carry (for subtract: 1 = no borrow).
- ovf  out  1  signed overflow of the unsaturated result.
- d_out_vld  out  1  sum/cout/ovf valid.
- d_out_rdy  in  1  downstream accepts result.

## Operation
- N = WIDTH/DIGIT digit steps.
- **States:**
  - IDLE: data_x_rdy = data_y_rdy = 1.
  - CALC: step counter 0..N−1.
  - DONE: d_out_vld = 1.
- **IDLE → CALC:** on an edge where data_x_vld & data_y_vld are both 1 (join; both rdy go high together).
  - On that edge, latch x, y^{WIDTH{sub}}, sub; set carry = sub; clear counter.
  - One valid alone: nothing is accepted; state is unchanged.
- **CALC, each cycle:**
  - Add DIGIT LSBs of the A and B shift registers plus carry.
  - Shift the result digit into the top of the sum shift register.
  - Shift A and B right by DIGIT; update carry; increment counter.
- **CALC → DONE:** when counter = N−1.
  - On that edge, register cout = final carry.
  - Register ovf = carry into MSB XOR carry out of MSB.
- **DONE → IDLE:** on d_out_rdy = 1. While d_out_rdy = 0, sum/cout/ovf are held stable.
- **Arithmetic:**
  - Result is modulo 2^WIDTH.
  - Inputs are ignored outside IDLE.
  - sub changing after acceptance has no effect.
- **Reset values (async assert at any time, including mid-CALC):**
  - State = IDLE; counter = 0; carry = 0.
  - sum = 0; cout = 0; ovf = 0; d_out_vld = 0.
  - data_x_rdy and data_y_rdy are 0 while reset is asserted and 1 in IDLE after release.
  - An in-flight operation is discarded and never emitted.

## Timing
- **Latency:** acceptance edge at cycle 0; d_out_vld rises after edge N (N cycles later).
- **Throughput:** one result per N+2 cycles when d_out_rdy is held at 1.
  - The DONE→IDLE edge and the next IDLE acceptance edge are distinct; no overlap.
- **Ready and valid registration:**
  - rdy outputs are registered from state; no combinational path from any *_vld.
  - d_out_vld is registered.
- **Reset release:** first acceptance is possible on the first rising edge after release.

## Configuration
- SERIAL_ADD_SAT_EN:
  - **Defined:** in DONE, if ovf = 1, sum is replaced by 0x7F…F (positive overflow, operand-B-effective sign 0) or 0x80…0 (negative overflow).
    - ovf still reports 1; cout is unchanged.
    - Replacement is applied on the CALC→DONE edge; latency is unchanged.
  - **Undefined:** sum wraps modulo 2^WIDTH; no saturation logic is synthesised.

## Structure
- **Package serial_fxp_pkg:**
  - State encoding constants: IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2.
  - Saturation max/min constant functions parametrised by width.
- **Sub-module serial_addsub_digit:**
  - Combinational DIGIT-bit ripple adder: a, b, cin → s, cout, plus carry-into-MSB for overflow.
  - Instantiated once.

## Test plan
- WIDTH=8, DIGIT=1, add 0x35 + 0x4A → sum = 0x7F, cout = 0, ovf = 0; d_out_vld exactly 8 cycles after acceptance.
- Add 0x7F + 0x01 → ovf = 1, cout = 0, sum = 0x80 without SERIAL_ADD_SAT_EN and 0x7F with it. Add 0x80 + 0xFF → ovf = 1, cout = 1, sum = 0x7F (wrap) or 0x80 (saturated).
- Subtract 0x10 − 0x20 → sum = 0xF0, cout = 0, ovf = 0. Subtract 0x20 − 0x10 → sum = 0x10, cout = 1.
- Only data_x_vld high for 5 cycles → no acceptance, data_x_rdy stays 1. Then d_out_rdy = 0 for 6 cycles in DONE → outputs stable, both rdy = 0.
- Assert asyn_reset mid-CALC at step 3 → all outputs 0 immediately. After release, 0x01 + 0x01 → 0x02 with no stale result emitted.
- WIDTH=16, DIGIT=4: 0x1234 + 0x0FFF → sum = 0x2233, latency 4 cycles. Back-to-back random vectors against a reference model, one result per 6 cycles.
